// File: rtl/lpc_host.sv
// LPC host cycle initiator: one request in, one LPC I/O read/write cycle on LFRAME#/LAD, one response out.
// Optional LPC_HOST_ABORT_EN: a SYNC timeout issues an LFRAME# abort sequence before responding.
module lpc_host #(
    parameter int SYNC_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [15:0] req_addr_i,
    input  logic [7:0]  req_data_i,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_data_o,
    output logic        rsp_err_o,
    output logic        lframe_o,
    inout  wire  [3:0]  lad_bus,
    output logic        lad_oe_o,
    output logic [4:0]  current_state_o
);
    localparam int CW = $clog2(SYNC_TIMEOUT + 1);

    typedef enum logic [4:0] {
        S_IDLE, S_START, S_CYCTYPE, S_ADDR1, S_ADDR2, S_ADDR3, S_ADDR4,
        S_WDATA1, S_WDATA2, S_TAR1, S_TAR2, S_SYNC, S_RDATA1, S_RDATA2,
        S_FTAR1, S_FTAR2
`ifdef LPC_HOST_ABORT_EN
        , S_ABORT, S_ABORT_END
`endif
    } state_t;

    state_t          state_q;
    logic            write_q;
    logic [15:0]     addr_q;
    logic [7:0]      data_q;
    logic [7:0]      rdata_q;
    logic            err_q;
    logic [CW-1:0]   wait_cnt_q;
    logic            lframe_q;
    logic            lad_oe_q;
    logic [3:0]      lad_q;
    logic            rsp_valid_q;
    logic [7:0]      rsp_data_q;
    logic            rsp_err_q;
`ifdef LPC_HOST_ABORT_EN
    logic [1:0]      abt_cnt_q;
`endif

    // Ready drops in the response clock so a held request lands one clock later.
    assign req_ready_o     = (state_q == S_IDLE) && !rsp_valid_q && !rst_i;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_data_o      = rsp_data_q;
    assign rsp_err_o       = rsp_err_q;
    assign lframe_o        = lframe_q;
    assign lad_oe_o        = lad_oe_q;
    assign lad_bus         = lad_oe_q ? lad_q : 4'bzzzz;
    assign current_state_o = state_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            write_q     <= 1'b0;
            addr_q      <= 16'h0000;
            data_q      <= 8'h00;
            rdata_q     <= 8'h00;
            err_q       <= 1'b0;
            wait_cnt_q  <= '0;
            lframe_q    <= 1'b1;
            lad_oe_q    <= 1'b0;
            lad_q       <= 4'h0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_err_q   <= 1'b0;
`ifdef LPC_HOST_ABORT_EN
            abt_cnt_q   <= 2'd0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: if (req_valid_i && req_ready_o) begin
                    write_q    <= req_write_i;
                    addr_q     <= req_addr_i;
                    data_q     <= req_data_i;
                    rdata_q    <= 8'h00;
                    err_q      <= 1'b0;
                    wait_cnt_q <= '0;
                    state_q    <= S_START;
                    lframe_q   <= 1'b0;
                    lad_oe_q   <= 1'b1;
                    lad_q      <= 4'h0;
                end
                S_START: begin
                    state_q  <= S_CYCTYPE;
                    lframe_q <= 1'b1;
                    lad_q    <= write_q ? 4'h2 : 4'h0;
                end
                S_CYCTYPE: begin state_q <= S_ADDR1; lad_q <= addr_q[15:12]; end
                S_ADDR1:   begin state_q <= S_ADDR2; lad_q <= addr_q[11:8];  end
                S_ADDR2:   begin state_q <= S_ADDR3; lad_q <= addr_q[7:4];   end
                S_ADDR3:   begin state_q <= S_ADDR4; lad_q <= addr_q[3:0];   end
                S_ADDR4: begin
                    state_q <= write_q ? S_WDATA1 : S_TAR1;
                    lad_q   <= write_q ? data_q[3:0] : 4'hF;
                end
                S_WDATA1: begin state_q <= S_WDATA2; lad_q <= data_q[7:4]; end
                S_WDATA2: begin state_q <= S_TAR1;   lad_q <= 4'hF;        end
                S_TAR1: begin
                    state_q  <= S_TAR2;
                    lad_oe_q <= 1'b0;
                end
                S_TAR2: state_q <= S_SYNC;
                S_SYNC: begin
                    case (lad_bus)
                        4'b0000, 4'b1010: begin
                            err_q   <= (lad_bus == 4'b1010);
                            state_q <= write_q ? S_FTAR1 : S_RDATA1;
                        end
                        4'b0110: ;  // long wait: never counts toward timeout
                        default: begin
                            if (wait_cnt_q >= CW'(SYNC_TIMEOUT - 1)) begin
                                wait_cnt_q <= CW'(SYNC_TIMEOUT);
                                err_q      <= 1'b1;
`ifdef LPC_HOST_ABORT_EN
                                state_q    <= S_ABORT;
                                abt_cnt_q  <= 2'd0;
                                lframe_q   <= 1'b0;
                                lad_oe_q   <= 1'b1;
                                lad_q      <= 4'hF;
`else
                                state_q     <= S_IDLE;
                                rsp_valid_q <= 1'b1;
                                rsp_err_q   <= 1'b1;
                                rsp_data_q  <= 8'h00;
`endif
                            end else begin
                                wait_cnt_q <= wait_cnt_q + 1'b1;
                            end
                        end
                    endcase
                end
                S_RDATA1: begin state_q <= S_RDATA2; rdata_q[3:0] <= lad_bus; end
                S_RDATA2: begin state_q <= S_FTAR1;  rdata_q[7:4] <= lad_bus; end
                S_FTAR1:  state_q <= S_FTAR2;
                S_FTAR2: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= err_q;
                    rsp_data_q  <= write_q ? 8'h00 : rdata_q;
                end
`ifdef LPC_HOST_ABORT_EN
                S_ABORT: begin
                    if (abt_cnt_q == 2'd3) begin
                        state_q  <= S_ABORT_END;
                        lframe_q <= 1'b1;
                        lad_oe_q <= 1'b0;
                    end else begin
                        abt_cnt_q <= abt_cnt_q + 2'd1;
                    end
                end
                S_ABORT_END: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    rsp_data_q  <= 8'h00;
                end
`endif
                default: begin
                    state_q  <= S_IDLE;
                    lframe_q <= 1'b1;
                    lad_oe_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lpc_host.sv
// Directed vector bench for lpc_host: a timed peripheral model answers SYNC/data by clock index after accept.
module tb_lpc_host;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [15:0] req_addr_i;
    logic [7:0]  req_data_i;
    logic        rsp_valid_o;
    logic [7:0]  rsp_data_o;
    logic        rsp_err_o;
    logic        lframe_o;
    wire  [3:0]  lad_bus;
    logic        lad_oe_o;
    logic [4:0]  current_state_o;
    logic [3:0]  per_lad = 4'hF;

    int checks = 0;
    int errors = 0;

`ifdef LPC_HOST_ABORT_EN
    localparam int ABORT_EXTRA = 5;
`else
    localparam int ABORT_EXTRA = 0;
`endif

    always #5 clk_i = ~clk_i;

    // Peripheral side: drives whenever the host has released the bus; idle level is the pull-up 1111.
    assign lad_bus = lad_oe_o ? 4'bzzzz : per_lad;

    lpc_host #(.SYNC_TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_write_i(req_write_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .lframe_o(lframe_o), .lad_bus(lad_bus), .lad_oe_o(lad_oe_o),
        .current_state_o(current_state_o)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
        int          nwait;
        logic [3:0]  wnib;
        logic [3:0]  snib;
        logic        to;
        logic [7:0]  rdata;
        int          lat;
        logic [7:0]  edata;
        logic        eerr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_nib(input vec_t v, input int k);
        logic [15:0] a;
        logic [7:0]  d;
        a = v.addr;
        d = v.data;
        case (k)
            1: return 4'h0;
            2: return v.wr ? 4'h2 : 4'h0;
            3: return a[15:12];
            4: return a[11:8];
            5: return a[7:4];
            6: return a[3:0];
            7: return v.wr ? d[3:0] : 4'hF;
            8: return d[7:4];
            default: return 4'hF;
        endcase
    endfunction

    task automatic run_txn(input vec_t v, input bit hold, output int waited);
        int s0, k, tar1;
        bit done;
        logic exp_oe, exp_fr;
        logic [3:0] d_lo, d_hi;
        s0 = v.wr ? 11 : 9;
        tar1 = v.wr ? 9 : 7;
        d_lo = v.rdata[3:0];
        d_hi = v.rdata[7:4];
        req_write_i = v.wr;
        req_addr_i  = v.addr;
        req_data_i  = v.data;
        req_valid_i = 1'b1;
        waited = 0;
        while (!req_ready_o && waited < 50) begin
            @(posedge clk_i); #1;
            waited++;
        end
        chk("accept_ready", {31'd0, req_ready_o}, 32'd1);
        k = 0;
        done = 0;
        while (!done) begin
            @(posedge clk_i); #1;
            k++;
            if (!hold && k == 1) begin
                // Post-accept changes must not reach the bus.
                req_valid_i = 1'b0;
                req_addr_i  = ~v.addr;
                req_data_i  = ~v.data;
                req_write_i = ~v.wr;
            end
            if (k >= s0 && (v.to || k < s0 + v.nwait)) per_lad = v.wnib;
            else if (k == s0 + v.nwait) per_lad = v.snib;
            else if (!v.wr && k == s0 + v.nwait + 1) per_lad = d_lo;
            else if (!v.wr && k == s0 + v.nwait + 2) per_lad = d_hi;
            else per_lad = 4'hF;
            exp_oe = (k <= tar1);
            exp_fr = (k != 1);
            if (v.to && ABORT_EXTRA != 0 && k >= s0 + 16 && k <= s0 + 19) begin
                exp_oe = 1'b1;
                exp_fr = 1'b0;
            end
            if (k < v.lat) begin
                chk("lframe", {31'd0, lframe_o}, {31'd0, exp_fr});
                chk("lad_oe", {31'd0, lad_oe_o}, {31'd0, exp_oe});
                if (exp_oe) chk("lad", {28'd0, lad_bus}, {28'd0, exp_nib(v, k)});
            end
            if (rsp_valid_o || k >= 120) done = 1;
        end
        per_lad = 4'hF;
        chk("rsp_latency", k, v.lat);
        chk("rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        chk("rsp_data", {24'd0, rsp_data_o}, {24'd0, v.edata});
        chk("rsp_err", {31'd0, rsp_err_o}, {31'd0, v.eerr});
        chk("ready_in_rsp", {31'd0, req_ready_o}, 32'd0);
        if (!hold) begin
            @(posedge clk_i); #1;
            chk("rsp_oneshot", {31'd0, rsp_valid_o}, 32'd0);
            chk("rsp_hold", {24'd0, rsp_data_o}, {24'd0, v.edata});
            chk("idle_ready", {31'd0, req_ready_o}, 32'd1);
        end
    endtask

    vec_t vt[10];
    int w;

    initial begin
        //        wr     addr      data   nw  wnib  snib  to    rdata  lat               edata  eerr
        vt[0] = '{1'b1, 16'h002E, 8'hA5, 0,  4'h5, 4'h0, 1'b0, 8'h00, 14,               8'h00, 1'b0};
        vt[1] = '{1'b0, 16'h0080, 8'h00, 0,  4'h5, 4'h0, 1'b0, 8'hC3, 14,               8'hC3, 1'b0};
        vt[2] = '{1'b0, 16'h1234, 8'h00, 3,  4'h5, 4'h0, 1'b0, 8'h5A, 17,               8'h5A, 1'b0};
        vt[3] = '{1'b1, 16'h0060, 8'h3C, 0,  4'h5, 4'hA, 1'b0, 8'h00, 14,               8'h00, 1'b1};
        vt[4] = '{1'b0, 16'h0070, 8'h00, 0,  4'hF, 4'hF, 1'b1, 8'h00, 25 + ABORT_EXTRA, 8'h00, 1'b1};
        vt[5] = '{1'b0, 16'hBEEF, 8'h00, 2,  4'h6, 4'h0, 1'b0, 8'h7E, 16,               8'h7E, 1'b0};
        vt[6] = '{1'b0, 16'hFFFF, 8'h00, 0,  4'h5, 4'hA, 1'b0, 8'h81, 14,               8'h81, 1'b1};
        vt[7] = '{1'b1, 16'h4321, 8'h96, 20, 4'h6, 4'h0, 1'b0, 8'h00, 34,               8'h00, 1'b0};
        vt[8] = '{1'b0, 16'h0A0B, 8'h00, 15, 4'h5, 4'h0, 1'b0, 8'hE4, 29,               8'hE4, 1'b0};
        vt[9] = '{1'b0, 16'h5555, 8'h00, 2,  4'h3, 4'h0, 1'b0, 8'h19, 16,               8'h19, 1'b0};

        rst_i = 1'b1;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_addr_i = 16'h0;
        req_data_i = 8'h0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_lframe", {31'd0, lframe_o}, 32'd1);
        chk("rst_oe", {31'd0, lad_oe_o}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_rsp_data", {24'd0, rsp_data_o}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err_o}, 32'd0);
        chk("rst_ready", {31'd0, req_ready_o}, 32'd0);
        rst_i = 1'b0;
        #1;
        chk("ready_after_rst", {31'd0, req_ready_o}, 32'd1);
        @(posedge clk_i); #1;

        for (int i = 0; i < 10; i++) run_txn(vt[i], 1'b0, w);

        // Request held valid: second one accepted exactly one clock after the response pulse.
        run_txn(vt[1], 1'b1, w);
        run_txn(vt[0], 1'b0, w);
        chk("b2b_accept_delay", w, 1);

        // Reset during ADDR3 aborts silently.
        req_write_i = 1'b0;
        req_addr_i  = 16'h0055;
        req_valid_i = 1'b1;
        #0;
        chk("mid_ready", {31'd0, req_ready_o}, 32'd1);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk_i); #1;
            req_valid_i = 1'b0;
        end
        chk("mid_addr3_oe", {31'd0, lad_oe_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_lframe", {31'd0, lframe_o}, 32'd1);
        chk("mid_rst_oe", {31'd0, lad_oe_o}, 32'd0);
        chk("mid_rst_ready", {31'd0, req_ready_o}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i); #1;
            chk("mid_rst_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
        end
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        chk("post_rst_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
        run_txn(vt[2], 1'b0, w);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/lpc_host.md
Name: lpc_host

Overview:
- LPC host-side cycle initiator: turns a single-entry request (16-bit I/O address, 8-bit data, read/write) into a complete LPC I/O read or write cycle on LFRAME#/LAD[3:0].
- Samples the peripheral's SYNC and read-data nibbles, then returns a one-shot response with read data and an error flag.
- Sits between host-side logic (test master or bridge) and the LPC bus, opposite the team's LPC peripheral.

Parameters:
- SYNC_TIMEOUT, 16, number of SYNC-phase clocks carrying short-wait (0101) or a non-SYNC value before the cycle is declared failed; long-wait (0110) clocks never count.

Ports:
- clk_i  input  1  LPC clock; all logic on rising edge
- rst_i  input  1  asynchronous active-high reset
- req_valid_i  input  1  request present
- req_ready_o  output  1  high only in IDLE with rst_i low; request accepted when valid & ready
- req_write_i  input  1  1 = I/O write, 0 = I/O read
- req_addr_i  input  16  I/O address, captured at accept
- req_data_i  input  8  write data, captured at accept
- rsp_valid_o  output  1  one-clock pulse at cycle end
- rsp_data_o  output  8  read data; 8'h00 for writes; held until next rsp_valid_o
- rsp_err_o  output  1  SYNC error (1010) or timeout; qualified by rsp_valid_o
- lframe_o  output  1  LFRAME#, active low
- lad_bus  inout  4  LAD[3:0]; driven only while lad_oe_o = 1, else 4'bzzzz
- lad_oe_o  output  1  host drive enable, exported for the bench
- current_state_o  output  5  FSM state encoding, for debug

Behaviour:
- Reset (async): state IDLE, lframe_o=1, lad_oe_o=0, rsp_valid_o=0, rsp_data_o=8'h00, rsp_err_o=0, wait counter 0, captured address/data/write cleared.
- Reset mid-cycle aborts immediately and silently:
  - Bus released, lframe_o=1.
  - No response is issued.
- FSM, one state per clock unless noted. "Drive X" means lad_oe_o=1 and LAD=X.
  - IDLE: on accept, capture request and go to START.
  - START: lframe_o=0, drive 0000.
  - CYCTYPE: lframe_o=1, drive 0000 (read) or 0010 (write).
  - ADDR1..ADDR4: drive addr[15:12], [11:8], [7:4], [3:0].
  - Write only, WDATA1, WDATA2: drive data[3:0], then data[7:4].
  - TAR1: drive 1111.
  - TAR2: tristate.
  - SYNC: tristate; sample LAD each clock.
    - 0000 → read: RDATA1; write: FTAR1.
    - 1010 → same exits as 0000, with error flag set.
    - 0101 → stay; wait counter +1.
    - 0110 → stay; counter unchanged.
    - Any other value → stay; counter +1.
    - Counter reaching SYNC_TIMEOUT → TIMEOUT: flag set, go to IDLE.
  - RDATA1, RDATA2: sample LAD into rsp_data_o[3:0], then [7:4].
  - FTAR1, FTAR2: tristate (peripheral drives 1111, then floats). Then IDLE, with rsp_valid_o=1 in that first IDLE clock.
- Zero-wait latency:
  - Accept at clock 0 → rsp_valid_o at clock 14, for both read and write.
  - Each wait clock adds 1.
- Timeout path:
  - rsp_valid_o=1, rsp_err_o=1.
  - rsp_data_o=8'h00.
- Request handling:
  - No new request is accepted while rsp_valid_o is high.
  - A request held valid is accepted the clock after rsp_valid_o.
  - req_* changes while not accepted are ignored.
- Wait counter clears at every accept; it saturates and never wraps.

Optional Feature:
- Macro: LPC_HOST_ABORT_EN.
- Defined: timeout enters ABORT instead of IDLE.
  - ABORT holds lframe_o=0 and drives 1111 for 4 clocks.
  - Then one clock lframe_o=1, tristate.
  - Then IDLE with the error response pulse.
  - Timeout latency grows by 5 clocks.
- Undefined: no ABORT state; timeout returns directly to IDLE with the error response; LFRAME# is never asserted outside START.

Test Plan:
- Write addr 16'h002E, data 8'hA5, peripheral SYNC 0000 immediately → LAD sequence 0,2,0,0,2,E,5,A,F; rsp_valid_o at clock 14; rsp_err_o=0.
- Read addr 16'h0080, peripheral SYNC 0000 then nibbles 3,C → rsp_data_o=8'hC3 at clock 14; rsp_err_o=0; lad_oe_o=0 from TAR2 through FTAR2.
- Read with 3× 0101 then 0000 → rsp_valid_o at clock 17; rsp_data_o correct.
- Write with SYNC 1010 → response at clock 14 with rsp_err_o=1.
- Read with LAD floating/pulled 1111 → timeout after 16 SYNC clocks; rsp_err_o=1, rsp_data_o=8'h00. With LPC_HOST_ABORT_EN: lframe_o low 4 clocks with LAD=1111 first.
- rst_i asserted during ADDR3 → immediate lframe_o=1, lad_oe_o=0, no rsp_valid_o; next request after reset completes normally.
